// File: rtl/lsu_mem_sequencer_if.sv
// Request/response handshake between core and LSU, and the word-addressed memory bus.
// Signal names match the original flat port list so existing hookups map one-to-one.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int unsigned ADDR_W = 21
);
    logic              cs;
    logic              wr;
    logic [3:0]        mask;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_wr;
    logic [31:0]       data_rd;

    modport master (
        output cs, wr, mask, addr, data_wr,
        input  data_rd
    );
    modport slave (
        input  cs, wr, mask, addr, data_wr,
        output data_rd
    );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// RV32I load/store sequencer in front of a word-addressed memory: splits misaligned
// accesses into two word transactions and merges/extends load data.
module lsu_mem_sequencer #(
    parameter int unsigned ADDR_W      = 21,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        RESP
    } state_t;

    state_t            state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;

    logic              mis_q;
    logic              req_bad;
    logic [3:0]        base_mask;
    logic [7:0]        m64;
    logic [63:0]       w64;
    logic [31:0]       sh;
    logic [31:0]       ext;

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return (f3 != 3'd3) && (f3 <= 3'd5);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size_code, input logic [1:0] off);
        return ((size_code == 2'd1) && (off == 2'd3)) ||
               ((size_code == 2'd2) && (off != 2'd0));
    endfunction

    assign mis_q   = is_misaligned(f3_q[1:0], off_q);
    assign req_bad = !is_legal(req.req_we, req.req_funct3) ||
                     (!MISALIGN_EN && is_misaligned(req.req_funct3[1:0], req.req_addr[1:0]));

    always_comb begin
        unique case (f3_q[1:0])
            2'd0:    base_mask = 4'b0001;
            2'd1:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        m64 = {4'b0000, base_mask} << off_q;
        w64 = {32'b0, wdata_q} << {off_q, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req.req_valid) begin
                we_q    <= req.req_we;
                f3_q    <= req.req_funct3;
                off_q   <= req.req_addr[1:0];
                wdata_q <= req.req_wdata;
                err_q   <= req_bad;
                if (!req_bad) addr_q <= req.req_addr[ADDR_W+1:2];
            end
            if (state == ACC_LO) begin
                if (!we_q) lo_q <= mem.data_rd;
                // word+1 wraps naturally at ADDR_W bits
                if (mis_q) addr_q <= addr_q + ADDR_W'(1);
            end
            if (state == ACC_HI && !we_q) hi_q <= mem.data_rd;
        end
    end

    always_comb begin
        state_nx    = state;
        mem.cs      = 1'b1;
        mem.wr      = 1'b1;
        mem.mask    = '0;
        mem.data_wr = '0;
        unique case (state)
            IDLE: begin
                if (req.req_valid) state_nx = req_bad ? RESP : ACC_LO;
            end
            ACC_LO: begin
                mem.cs      = 1'b0;
                mem.wr      = ~we_q;
                mem.mask    = m64[3:0];
                mem.data_wr = w64[31:0];
                state_nx    = mis_q ? ACC_HI : RESP;
            end
            ACC_HI: begin
                mem.cs      = 1'b0;
                mem.wr      = ~we_q;
                mem.mask    = m64[7:4];
                mem.data_wr = w64[63:32];
                state_nx    = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // a reset landing mid-access must never let a write reach memory
        if (rst) begin
            mem.cs      = 1'b1;
            mem.wr      = 1'b1;
            mem.mask    = '0;
            mem.data_wr = '0;
        end
    end

    always_comb begin
        sh  = 32'({hi_q, lo_q} >> {off_q, 3'b000});
        ext = '0;
        case (f3_q)
            3'd0:    ext = {{24{sh[7]}}, sh[7:0]};
            3'd1:    ext = {{16{sh[15]}}, sh[15:0]};
            3'd2:    ext = sh;
            3'd4:    ext = {24'b0, sh[7:0]};
            3'd5:    ext = {16'b0, sh[15:0]};
            default: ext = '0;
        endcase
    end

    assign mem.addr       = addr_q;
    assign req.req_ready  = (state == IDLE) && !rst;
    assign req.resp_valid = (state == RESP);
    assign req.resp_err   = (state == RESP) && err_q;
    assign req.resp_rdata = (state == RESP && !err_q && !we_q) ? ext : '0;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: one split-capable instance with a small
// memory model, plus one MISALIGN_EN=0 instance for the misaligned-error path.
module tb_lsu_mem_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if                  r1 ();
    lsu_req_if                  r2 ();
    lsu_mem_if #(.ADDR_W(21))   m1 ();
    lsu_mem_if #(.ADDR_W(21))   m2 ();

    lsu_mem_sequencer #(.ADDR_W(21), .MISALIGN_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req(r1), .mem(m1)
    );
    lsu_mem_sequencer #(.ADDR_W(21), .MISALIGN_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .req(r2), .mem(m2)
    );

    // memory model indexed by the low 8 word-address bits
    logic [31:0] mem1 [256];
    always @(posedge clk) begin
        if (!m1.cs && !m1.wr) begin
            for (int i = 0; i < 4; i++)
                if (m1.mask[i]) mem1[m1.addr[7:0]][8*i +: 8] <= m1.data_wr[8*i +: 8];
        end
    end
    assign m1.data_rd = mem1[m1.addr[7:0]];
    assign m2.data_rd = 32'h0;

    logic        sel = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_we = 1'b0;
    logic [2:0]  t_f3 = '0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;

    assign r1.req_valid  = t_valid & ~sel;
    assign r2.req_valid  = t_valid & sel;
    assign r1.req_we     = t_we;
    assign r2.req_we     = t_we;
    assign r1.req_funct3 = t_f3;
    assign r2.req_funct3 = t_f3;
    assign r1.req_addr   = t_addr;
    assign r2.req_addr   = t_addr;
    assign r1.req_wdata  = t_wdata;
    assign r2.req_wdata  = t_wdata;

    logic        o_ready, o_rv, o_err, o_cs, o_wr;
    logic [31:0] o_rdata, o_dwr;
    logic [3:0]  o_mask;
    logic [20:0] o_addr;
    assign o_ready = sel ? r2.req_ready  : r1.req_ready;
    assign o_rv    = sel ? r2.resp_valid : r1.resp_valid;
    assign o_err   = sel ? r2.resp_err   : r1.resp_err;
    assign o_rdata = sel ? r2.resp_rdata : r1.resp_rdata;
    assign o_cs    = sel ? m2.cs         : m1.cs;
    assign o_wr    = sel ? m2.wr         : m1.wr;
    assign o_mask  = sel ? m2.mask       : m1.mask;
    assign o_addr  = sel ? m2.addr       : m1.addr;
    assign o_dwr   = sel ? m2.data_wr    : m1.data_wr;

    int checks = 0;
    int errors = 0;

    int          n_acc, lat, busy_ready;
    logic        got, r_err;
    logic [31:0] r_rdata;
    logic        acc_wr   [4];
    logic [3:0]  acc_mask [4];
    logic [20:0] acc_addr [4];
    logic [31:0] acc_data [4];

    // Issues one request and records every memory access cycle up to the response.
    // lat counts cycles inclusively from the accepting cycle to the resp_valid cycle.
    task automatic drive_req(input logic s, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        int wait_n;
        n_acc = 0; lat = 0; got = 1'b0; r_err = 1'b0; r_rdata = '0; busy_ready = 0;
        @(negedge clk);
        sel = s; t_valid = 1'b1; t_we = we; t_f3 = f3; t_addr = a; t_wdata = wd;
        #1;
        wait_n = 0;
        while (!o_ready && wait_n < 20) begin
            @(negedge clk); #1; wait_n++;
        end
        @(negedge clk); #1;
        t_valid = 1'b0;
        lat = 2;
        for (int i = 0; i < 8; i++) begin
            if (!o_cs) begin
                if (n_acc < 4) begin
                    acc_wr[n_acc]   = o_wr;
                    acc_mask[n_acc] = o_mask;
                    acc_addr[n_acc] = o_addr;
                    acc_data[n_acc] = o_dwr;
                end
                n_acc++;
            end
            if (o_ready) busy_ready++;
            if (o_rv) begin
                got = 1'b1; r_rdata = o_rdata; r_err = o_err;
                break;
            end
            @(negedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", o_ready); end
        checks++; if (o_rv !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_resp: got rv=%b err=%b rdata=%h exp 0/0/0", o_rv, o_err, o_rdata); end
        checks++; if (o_cs !== 1'b1 || o_wr !== 1'b1) begin
            errors++; $display("FAIL reset_cs_wr: got cs=%b wr=%b exp 1/1", o_cs, o_wr); end
        checks++; if (o_mask !== 4'h0 || o_addr !== 21'h0 || o_dwr !== 32'h0) begin
            errors++; $display("FAIL reset_bus: got mask=%h addr=%h data=%h exp 0/0/0", o_mask, o_addr, o_dwr); end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b exp 1", o_ready); end
    endtask

    task automatic test_word;
        drive_req(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        checks++; if (n_acc !== 1) begin errors++; $display("FAIL sw_acc_count: got %0d exp 1", n_acc); end
        checks++; if (acc_wr[0] !== 1'b0 || acc_mask[0] !== 4'b1111 || acc_addr[0] !== 21'h40 || acc_data[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_bus: got wr=%b mask=%b addr=%h data=%h exp 0/1111/40/deadbeef",
                               acc_wr[0], acc_mask[0], acc_addr[0], acc_data[0]); end
        checks++; if (!got || lat !== 3 || r_err !== 1'b0 || r_rdata !== 32'h0) begin
            errors++; $display("FAIL sw_resp: got got=%b lat=%0d err=%b rdata=%h exp 1/3/0/0", got, lat, r_err, r_rdata); end
        checks++; if (busy_ready !== 0) begin errors++; $display("FAIL sw_busy_ready: got %0d exp 0", busy_ready); end
        drive_req(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
        checks++; if (n_acc !== 1 || acc_wr[0] !== 1'b1 || acc_mask[0] !== 4'b1111 || acc_addr[0] !== 21'h40) begin
            errors++; $display("FAIL lw_bus: got n=%0d wr=%b mask=%b addr=%h exp 1/1/1111/40", n_acc, acc_wr[0], acc_mask[0], acc_addr[0]); end
        checks++; if (!got || lat !== 3 || r_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_resp: got got=%b lat=%0d rdata=%h exp 1/3/deadbeef", got, lat, r_rdata); end
    endtask

    task automatic test_byte_half;
        drive_req(1'b0, 1'b1, 3'd0, 32'h102, 32'h00000080);
        checks++; if (n_acc !== 1 || acc_mask[0] !== 4'b0100 || acc_data[0] !== 32'h00800000 || acc_addr[0] !== 21'h40) begin
            errors++; $display("FAIL sb_bus: got n=%0d mask=%b data=%h addr=%h exp 1/0100/00800000/40",
                               n_acc, acc_mask[0], acc_data[0], acc_addr[0]); end
        drive_req(1'b0, 1'b0, 3'd0, 32'h102, 32'h0);
        checks++; if (r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h exp ffffff80", r_rdata); end
        drive_req(1'b0, 1'b0, 3'd4, 32'h102, 32'h0);
        checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h exp 00000080", r_rdata); end
        drive_req(1'b0, 1'b0, 3'd1, 32'h102, 32'h0);
        checks++; if (r_rdata !== 32'hFFFFDE80 || lat !== 3) begin
            errors++; $display("FAIL lh_off2: got %h lat=%0d exp ffffde80/3", r_rdata, lat); end
        drive_req(1'b0, 1'b0, 3'd5, 32'h102, 32'h0);
        checks++; if (r_rdata !== 32'h0000DE80) begin errors++; $display("FAIL lhu_off2: got %h exp 0000de80", r_rdata); end
        drive_req(1'b0, 1'b0, 3'd1, 32'h101, 32'h0);
        checks++; if (r_rdata !== 32'hFFFF80BE || n_acc !== 1) begin
            errors++; $display("FAIL lh_off1: got %h n=%0d exp ffff80be/1", r_rdata, n_acc); end
    endtask

    task automatic test_misaligned;
        drive_req(1'b0, 1'b1, 3'd2, 32'h105, 32'h11223344);
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL msw_acc_count: got %0d exp 2", n_acc); end
        checks++; if (acc_addr[0] !== 21'h41 || acc_mask[0] !== 4'b1110 || acc_data[0] !== 32'h22334400 || acc_wr[0] !== 1'b0) begin
            errors++; $display("FAIL msw_lo: got addr=%h mask=%b data=%h wr=%b exp 41/1110/22334400/0",
                               acc_addr[0], acc_mask[0], acc_data[0], acc_wr[0]); end
        checks++; if (acc_addr[1] !== 21'h42 || acc_mask[1] !== 4'b0001 || acc_data[1] !== 32'h00000011 || acc_wr[1] !== 1'b0) begin
            errors++; $display("FAIL msw_hi: got addr=%h mask=%b data=%h wr=%b exp 42/0001/00000011/0",
                               acc_addr[1], acc_mask[1], acc_data[1], acc_wr[1]); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL msw_lat: got %0d exp 4", lat); end
        drive_req(1'b0, 1'b0, 3'd2, 32'h105, 32'h0);
        checks++; if (!got || lat !== 4 || r_rdata !== 32'h11223344) begin
            errors++; $display("FAIL mlw: got got=%b lat=%0d rdata=%h exp 1/4/11223344", got, lat, r_rdata); end
        drive_req(1'b0, 1'b0, 3'd1, 32'h107, 32'h0);
        checks++; if (n_acc !== 2 || lat !== 4 || r_rdata !== 32'h00001122) begin
            errors++; $display("FAIL mlh_off3: got n=%0d lat=%0d rdata=%h exp 2/4/00001122", n_acc, lat, r_rdata); end
    endtask

    task automatic test_wrap;
        drive_req(1'b0, 1'b1, 3'd2, 32'h007FFFFC, 32'hA1B2C3D4);
        checks++; if (acc_addr[0] !== 21'h1FFFFF) begin errors++; $display("FAIL top_sw_addr: got %h exp 1fffff", acc_addr[0]); end
        drive_req(1'b0, 1'b1, 3'd2, 32'h00000000, 32'h55667788);
        drive_req(1'b0, 1'b0, 3'd1, 32'h007FFFFF, 32'h0);
        checks++; if (n_acc !== 2 || acc_addr[0] !== 21'h1FFFFF || acc_addr[1] !== 21'h0) begin
            errors++; $display("FAIL wrap_addr: got n=%0d lo=%h hi=%h exp 2/1fffff/0", n_acc, acc_addr[0], acc_addr[1]); end
        checks++; if (acc_mask[0] !== 4'b1000 || acc_mask[1] !== 4'b0001) begin
            errors++; $display("FAIL wrap_mask: got %b/%b exp 1000/0001", acc_mask[0], acc_mask[1]); end
        checks++; if (r_rdata !== 32'hFFFF88A1 || lat !== 4 || r_err !== 1'b0) begin
            errors++; $display("FAIL wrap_lh: got rdata=%h lat=%0d err=%b exp ffff88a1/4/0", r_rdata, lat, r_err); end
    endtask

    task automatic test_no_misalign;
        drive_req(1'b1, 1'b0, 3'd1, 32'h007FFFFF, 32'h0);
        checks++; if (!got || r_err !== 1'b1 || r_rdata !== 32'h0 || n_acc !== 0) begin
            errors++; $display("FAIL nm_lh_wrap: got got=%b err=%b rdata=%h n=%0d exp 1/1/0/0", got, r_err, r_rdata, n_acc); end
        drive_req(1'b1, 1'b0, 3'd2, 32'h102, 32'h0);
        checks++; if (r_err !== 1'b1 || n_acc !== 0) begin
            errors++; $display("FAIL nm_lw_off2: got err=%b n=%0d exp 1/0", r_err, n_acc); end
        drive_req(1'b1, 1'b0, 3'd1, 32'h101, 32'h0);
        checks++; if (r_err !== 1'b0 || n_acc !== 1 || lat !== 3) begin
            errors++; $display("FAIL nm_lh_off1: got err=%b n=%0d lat=%0d exp 0/1/3", r_err, n_acc, lat); end
    endtask

    task automatic test_illegal;
        drive_req(1'b0, 1'b0, 3'd3, 32'h100, 32'h0);
        checks++; if (!got || r_err !== 1'b1 || r_rdata !== 32'h0 || n_acc !== 0) begin
            errors++; $display("FAIL ill_load3: got got=%b err=%b rdata=%h n=%0d exp 1/1/0/0", got, r_err, r_rdata, n_acc); end
        drive_req(1'b0, 1'b1, 3'd5, 32'h100, 32'h12345678);
        checks++; if (!got || r_err !== 1'b1 || r_rdata !== 32'h0 || n_acc !== 0) begin
            errors++; $display("FAIL ill_store5: got got=%b err=%b rdata=%h n=%0d exp 1/1/0/0", got, r_err, r_rdata, n_acc); end
        drive_req(1'b0, 1'b0, 3'd7, 32'h100, 32'h0);
        checks++; if (r_err !== 1'b1 || n_acc !== 0) begin
            errors++; $display("FAIL ill_load7: got err=%b n=%0d exp 1/0", r_err, n_acc); end
        drive_req(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'hDE80BEEF) begin
            errors++; $display("FAIL ill_no_side_effect: got err=%b rdata=%h exp 0/de80beef", r_err, r_rdata); end
    endtask

    task automatic test_reset_mid_access;
        drive_req(1'b0, 1'b1, 3'd2, 32'h10C, 32'hCAFEF00D);
        @(negedge clk);
        sel = 1'b0; t_valid = 1'b1; t_we = 1'b1; t_f3 = 3'd2; t_addr = 32'h109; t_wdata = 32'h99887766;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rma_ready: got %b exp 1", o_ready); end
        @(negedge clk); #1;
        t_valid = 1'b0;
        checks++; if (o_cs !== 1'b0 || o_addr !== 21'h42 || o_mask !== 4'b1110) begin
            errors++; $display("FAIL rma_lo: got cs=%b addr=%h mask=%b exp 0/42/1110", o_cs, o_addr, o_mask); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (o_cs !== 1'b1 || o_wr !== 1'b1) begin
            errors++; $display("FAIL rma_hi_forced: got cs=%b wr=%b exp 1/1", o_cs, o_wr); end
        @(negedge clk); #1;
        checks++; if (o_ready !== 1'b0 || o_rv !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h0 || o_cs !== 1'b1 ||
                      o_wr !== 1'b1 || o_mask !== 4'h0 || o_addr !== 21'h0 || o_dwr !== 32'h0) begin
            errors++; $display("FAIL rma_after: got rdy=%b rv=%b err=%b rd=%h cs=%b wr=%b mask=%h addr=%h dw=%h exp all reset values",
                               o_ready, o_rv, o_err, o_rdata, o_cs, o_wr, o_mask, o_addr, o_dwr); end
        rst = 1'b0;
        drive_req(1'b0, 1'b0, 3'd2, 32'h10C, 32'h0);
        checks++; if (r_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rma_hi_word: got %h exp cafef00d", r_rdata); end
        drive_req(1'b0, 1'b0, 3'd2, 32'h108, 32'h0);
        checks++; if (r_rdata !== 32'h88776611) begin errors++; $display("FAIL rma_lo_word: got %h exp 88776611", r_rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem1[i] = '0;
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_wrap();
        test_no_misalign();
        test_illegal();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
